// File: rtl/i2s_receiver.sv
// i2s_receiver: recovers left/right PCM words from an I2S stream in the
// bit-clock domain and presents completed stereo pairs to the effects
// pipeline. Mis-framed slots are dropped and the receiver resynchronises on
// the next word-select edge.
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_MAX   = 32
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  lrclk,
  input  logic                  sdin,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  frame_valid,
  output logic                  sync_err
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int SW = $clog2(SLOT_MAX + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT
  } state_t;

  state_t                state;
  logic                  prev_lr;
  logic                  channel;
  logic                  left_seen;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BW-1:0]         bit_cnt;
  logic [SW-1:0]         slot_cnt;
  logic                  ws_edge;

  // A word-select edge is any change of lrclk between consecutive sclk edges.
  assign ws_edge = (lrclk != prev_lr);

  // Shift register contents once the current sdin bit has been taken in.
  always_comb begin
    shift_next = {shift_reg[DATA_WIDTH-2:0], sdin};
  end

  // Framing FSM: slot start, bit capture, word commit, pairing and fault handling.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state       <= S_IDLE;
      prev_lr     <= lrclk;
      channel     <= 1'b0;
      left_seen   <= 1'b0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      left_data   <= '0;
      right_data  <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      prev_lr     <= lrclk;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (ws_edge) begin
        // A new slot always starts capture; if one was still in progress it
        // is thrown away and the pairing is broken.
        if (state == S_CAPTURE) begin
          sync_err  <= 1'b1;
          left_seen <= 1'b0;
        end
        state     <= S_CAPTURE;
        channel   <= lrclk;
        shift_reg <= '0;
        bit_cnt   <= BW'(DATA_WIDTH - 1);
        slot_cnt  <= '0;
      end else if (state != S_IDLE) begin
        if (slot_cnt == SW'(SLOT_MAX)) begin
          // Slot has run past its longest legal length: drop back and wait
          // for a fresh word-select edge.
          sync_err  <= 1'b1;
          left_seen <= 1'b0;
          state     <= S_IDLE;
          slot_cnt  <= '0;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
          if (state == S_CAPTURE) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt - 1'b1;
            if (bit_cnt == '0) begin
              state <= S_WAIT;
              if (channel == 1'b0) begin
                left_data <= shift_next;
                left_seen <= 1'b1;
              end else begin
                right_data  <= shift_next;
                frame_valid <= left_seen;
                left_seen   <= 1'b0;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S slots against a history-based model of the
// receiver, checked on every sclk edge, plus literal checks of decoded words.
module tb_i2s_receiver;

  localparam int W  = 24;
  localparam int SM = 32;
  localparam int HN = 8192;

  logic         sclk = 1'b0;
  logic         rst;
  logic         lrclk;
  logic         sdin;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         frame_valid;
  logic         sync_err;

  int checks = 0;
  int fails  = 0;

  // Model state: raw sample history since the last reset.
  bit           lr_h [HN];
  bit           sd_h [HN];
  int           n        = 0;
  int           last_ws  = -1;
  bit           lr_reset = 1'b0;
  bit           left_seen_m = 1'b0;
  logic [W-1:0] exp_left  = '0;
  logic [W-1:0] exp_right = '0;
  bit           exp_fv = 1'b0;
  bit           exp_se = 1'b0;

  // Observed pulse bookkeeping for literal checks.
  int edge_no = 0;
  int fv_cnt  = 0;
  int se_cnt  = 0;
  int fv_edge [$];

  i2s_receiver #(.DATA_WIDTH(W), .SLOT_MAX(SM)) dut (
    .sclk        (sclk),
    .rst         (rst),
    .lrclk       (lrclk),
    .sdin        (sdin),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  // Free-running bit clock.
  always #5 sclk = ~sclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_no, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit lr, input bit sd);
    @(negedge sclk);
    lrclk = lr;
    sdin  = sd;
  endtask

  // One slot: edge 0 is the word-select edge, edges 1..W carry the word MSB
  // first, anything after that is random filler.
  task automatic sendSlot(input bit lr, input logic [W-1:0] word, input int len);
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= W) applyStimulus(lr, word[W-i]);
      else                  applyStimulus(lr, 1'($urandom));
    end
  endtask

  // Model and per-edge comparison. A word commits exactly W edges after a
  // word-select edge if no other edge intervened; a fault is a select edge
  // within W edges of the previous one, or SM+1 edges with no select edge.
  initial begin
    bit s_rst, s_lr, s_sd, prev, ws;
    logic [W-1:0] word;
    forever begin
      @(posedge sclk);
      s_rst = rst;
      s_lr  = lrclk;
      s_sd  = sdin;
      edge_no++;
      #1;
      exp_fv = 1'b0;
      exp_se = 1'b0;
      if (s_rst) begin
        lr_reset    = s_lr;
        n           = 0;
        last_ws     = -1;
        left_seen_m = 1'b0;
        exp_left    = '0;
        exp_right   = '0;
      end else if (n < HN) begin
        lr_h[n] = s_lr;
        sd_h[n] = s_sd;
        prev = (n == 0) ? lr_reset : lr_h[n-1];
        ws = (s_lr != prev);
        if (ws) begin
          if (last_ws >= 0 && (n - last_ws) <= W) begin
            exp_se      = 1'b1;
            left_seen_m = 1'b0;
          end
          last_ws = n;
        end else if (last_ws >= 0) begin
          if ((n - last_ws) == W) begin
            for (int i = 0; i < W; i++) word[W-1-i] = sd_h[last_ws+1+i];
            if (lr_h[last_ws] == 1'b0) begin
              exp_left    = word;
              left_seen_m = 1'b1;
            end else begin
              exp_right   = word;
              exp_fv      = left_seen_m;
              left_seen_m = 1'b0;
            end
          end
          if ((n - last_ws) == SM + 1) begin
            exp_se      = 1'b1;
            left_seen_m = 1'b0;
          end
        end
        n++;
      end
      checkOutput("left_data",   32'(left_data),   32'(exp_left));
      checkOutput("right_data",  32'(right_data),  32'(exp_right));
      checkOutput("frame_valid", 32'(frame_valid), 32'(exp_fv));
      checkOutput("sync_err",    32'(sync_err),    32'(exp_se));
      if (frame_valid === 1'b1) begin
        fv_cnt++;
        fv_edge.push_back(edge_no);
      end
      if (sync_err === 1'b1) se_cnt++;
    end
  end

  // Directed scenario sequence with literal expectations.
  initial begin
    rst   = 1'b1;
    lrclk = 1'b1;
    sdin  = 1'b0;

    // Reset with lrclk high so the first left slot produces a select edge.
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("reset_left",  32'(left_data),   32'h0);
    checkOutput("reset_right", 32'(right_data),  32'h0);
    checkOutput("reset_fv",    32'(frame_valid), 32'h0);
    rst = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'(($urandom)));

    // Basic stereo frame.
    sendSlot(1'b0, 24'h123456, 32);
    sendSlot(1'b1, 24'hABCDEF, 32);
    checkOutput("s1_left",  32'(left_data),  32'h123456);
    checkOutput("s1_right", 32'(right_data), 32'hABCDEF);
    checkOutput("s1_fv_cnt", 32'(fv_cnt), 32'd1);

    // Back-to-back frames with extreme values.
    sendSlot(1'b0, 24'h800000, 32);
    sendSlot(1'b1, 24'h7FFFFF, 32);
    checkOutput("s2a_left",  32'(left_data),  32'h800000);
    checkOutput("s2a_right", 32'(right_data), 32'h7FFFFF);
    sendSlot(1'b0, 24'h000001, 32);
    sendSlot(1'b1, 24'hFFFFFE, 32);
    checkOutput("s2b_left",  32'(left_data),  32'h000001);
    checkOutput("s2b_right", 32'(right_data), 32'hFFFFFE);
    checkOutput("s2_fv_cnt", 32'(fv_cnt), 32'd3);
    if (fv_edge.size() >= 3)
      checkOutput("s2_fv_spacing", 32'(fv_edge[2] - fv_edge[1]), 32'd64);

    // Stream starting on a right slot after reset.
    rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0);
    sendSlot(1'b1, 24'h55AA33, 32);
    checkOutput("s3_right_only", 32'(right_data), 32'h55AA33);
    checkOutput("s3_left_zero",  32'(left_data),  32'h0);
    checkOutput("s3_fv_cnt0",    32'(fv_cnt),     32'd3);
    sendSlot(1'b0, 24'h111111, 32);
    sendSlot(1'b1, 24'h222222, 32);
    checkOutput("s3_left",    32'(left_data),  32'h111111);
    checkOutput("s3_right",   32'(right_data), 32'h222222);
    checkOutput("s3_fv_cnt1", 32'(fv_cnt),     32'd4);

    // lrclk toggles after 10 bits of a left word.
    sendSlot(1'b0, 24'hFACE00, 11);
    sendSlot(1'b1, 24'h0F0F0F, 32);
    checkOutput("s4_se_cnt", 32'(se_cnt),     32'd1);
    checkOutput("s4_left",   32'(left_data),  32'h111111);
    checkOutput("s4_right",  32'(right_data), 32'h0F0F0F);
    checkOutput("s4_fv_cnt", 32'(fv_cnt),     32'd4);

    // Overlong slot: lrclk held for 40 edges.
    sendSlot(1'b0, 24'h333333, 40);
    checkOutput("s5_se_cnt", 32'(se_cnt),    32'd2);
    checkOutput("s5_left",   32'(left_data), 32'h333333);
    sendSlot(1'b1, 24'h444444, 32);
    checkOutput("s5_right",   32'(right_data), 32'h444444);
    checkOutput("s5_fv_cnt0", 32'(fv_cnt),     32'd4);
    sendSlot(1'b0, 24'h565656, 32);
    sendSlot(1'b1, 24'h787878, 32);
    checkOutput("s5_left2",   32'(left_data),  32'h565656);
    checkOutput("s5_right2",  32'(right_data), 32'h787878);
    checkOutput("s5_fv_cnt1", 32'(fv_cnt),     32'd5);

    // Reset in the middle of a captured word, lrclk changing during reset.
    sendSlot(1'b0, 24'hDEADBE, 12);
    applyStimulus(1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s6_rst_left",  32'(left_data),  32'h0);
    checkOutput("s6_rst_right", 32'(right_data), 32'h0);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b1, 1'b1);
    checkOutput("s6_no_false_se", 32'(se_cnt), 32'd2);
    sendSlot(1'b0, 24'h9ABCDE, 32);
    sendSlot(1'b1, 24'h13579B, 32);
    checkOutput("s6_left",   32'(left_data),  32'h9ABCDE);
    checkOutput("s6_right",  32'(right_data), 32'h13579B);
    checkOutput("s6_fv_cnt", 32'(fv_cnt),     32'd6);
    checkOutput("s6_se_cnt", 32'(se_cnt),     32'd2);

    applyStimulus(1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
